// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter: FSM state type, the number of
// s_tick pulses per bit period, and default frame parameters.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> state type includes ST_PARITY (even parity bit after data)
//   undefined -> no parity state
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int DEF_DBIT      = 8;
    localparam int DEF_SB_TICK   = 16;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    // The tick counter is nominally 4 bits (one bit period), but a stop
    // interval longer than one bit (SB_TICK = 24 or 32) needs a wider counter.
    function automatic int s_width(input int sb_tick);
        int w;
        w = $clog2(sb_tick);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/tx_hold_buf.sv
// ---------------------------------------------------------------------------
// tx_hold_buf
// Single-entry holding register between the host and the transmitter FSM.
//
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous, active-high reset
//   set    in   load d and mark the entry occupied
//   clear  in   release the entry (FSM has taken the word)
//   d      in   [W-1:0] data to load
//   q      out  [W-1:0] stored data
//   full   out  entry occupied
//
// set has priority over clear so that a word written in the same cycle the
// FSM takes the previous one is kept.
// ---------------------------------------------------------------------------
module tx_hold_buf #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         set,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         full
);

    logic [W-1:0] r_q;
    logic         r_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_full <= 1'b0;
        end else if (set) begin
            r_q    <= d;
            r_full <= 1'b1;
        end else if (clear) begin
            r_full <= 1'b0;
        end
    end

    assign q    = r_q;
    assign full = r_full;

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: single-entry holding buffer feeding a start/data/stop
// framing FSM driven by a 16x oversampled baud tick.
//
// Parameters:
//   DBIT     data bits per frame
//   SB_TICK  s_tick count for the stop interval (16, 24 or 32)
//
// Ports:
//   clock         in   system clock
//   reset         in   asynchronous, active-high reset
//   s_tick        in   baud tick, 16 per bit period, one clock wide
//   wr            in   host write strobe
//   din           in   [DBIT-1:0] host write data
//   full          out  holding buffer occupied, host must not write
//   tx            out  serial line (registered, idle high)
//   tx_busy       out  frame in progress
//   tx_done_tick  out  one-clock pulse when the stop interval ends
//
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the last data bit and the stop interval.
//
// State table:
//   state     | meaning
//   ST_IDLE   | line high, waiting for the holding buffer to fill
//   ST_START  | start bit, tx low for one bit period
//   ST_DATA   | data bits, LSB first, one bit period each
//   ST_PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   ST_STOP   | stop interval, tx high for SB_TICK ticks
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            wr,
    input  logic [DBIT-1:0] din,
    output logic            full,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int SW = s_width(SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(TICKS_PER_BIT - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [SW-1:0]   r_s;
    logic [SW-1:0]   w_s_next;
    logic [NW-1:0]   r_n;
    logic [NW-1:0]   w_n_next;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] w_shift_next;
    logic            r_tx;
    logic            w_tx_next;
    logic            r_done;
    logic            w_done_next;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
    logic            w_par_next;
`endif

    logic            w_set;
    logic            w_clear;
    logic            w_full;
    logic [DBIT-1:0] w_buf_q;

    // A write is accepted when the buffer is empty, or when the FSM takes the
    // current word on this same edge.
    assign w_set = wr & (~w_full | w_clear);

    tx_hold_buf #(
        .W (DBIT)
    ) u_hold (
        .clock (clock),
        .reset (reset),
        .set   (w_set),
        .clear (w_clear),
        .d     (din),
        .q     (w_buf_q),
        .full  (w_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

    // tx is registered from the level belonging to the next state, so the
    // line changes on the same edge as the state and never glitches.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_done_next  = 1'b0;
        w_clear      = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (w_full) begin
                    w_state_next = ST_START;
                    w_shift_next = w_buf_q;
                    w_s_next     = '0;
                    w_clear      = 1'b1;
                    w_tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    // Parity is captured up front since shifting consumes the word.
                    w_par_next   = ^w_buf_q;
`endif
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_state_next = ST_DATA;
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_tx_next    = r_shift[0];
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_next     = '0;
                        w_shift_next = r_shift >> 1;
                        if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_par;
`else
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
`endif
                        end else begin
                            w_n_next  = r_n + 1'b1;
                            w_tx_next = w_shift_next[0];
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_state_next = ST_STOP;
                        w_s_next     = '0;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (r_s == S_STOP_LAST) begin
                        w_state_next = ST_IDLE;
                        w_s_next     = '0;
                        w_done_next  = 1'b1;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    assign full         = w_full;
    assign tx           = r_tx;
    assign tx_busy      = (r_state != ST_IDLE);
    assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. A frame-level model (tick index within the
// frame, plain bit lookup) predicts tx/full/tx_busy/tx_done_tick every cycle;
// directed sequences add literal expectations. A second instance with
// SB_TICK=32 covers the long stop interval and s_tick gating.
// ---------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int DBIT        = 8;
    localparam int SB          = 16;
    localparam int FRAME_TICKS = 16 * (1 + DBIT + PAR) + SB;
    localparam int NB          = 1 + DBIT + PAR + 1;
    localparam int D2_DONE     = 16 * (1 + DBIT + PAR) + 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic s_tick = 1'b0;
    logic wr = 1'b0;
    logic [7:0] din = '0;
    logic full, tx, tx_busy, tx_done_tick;

    logic s_tick2 = 1'b0;
    logic wr2 = 1'b0;
    logic [7:0] din2 = '0;
    logic full2, tx2, tx_busy2, tx_done_tick2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB)) dut (
        .clock(clock), .reset(reset), .s_tick(s_tick), .wr(wr), .din(din),
        .full(full), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    uart_tx #(.DBIT(DBIT), .SB_TICK(32)) dut2 (
        .clock(clock), .reset(reset), .s_tick(s_tick2), .wr(wr2), .din(din2),
        .full(full2), .tx(tx2), .tx_busy(tx_busy2), .tx_done_tick(tx_done_tick2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Level of the line at a given bit index of a frame carrying word w.
    function automatic logic exp_bit(input logic [7:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DBIT) return w[idx-1];
        if (PAR == 1 && idx == DBIT + 1) return ^w;
        return 1'b1;
    endfunction

    // ---------------- frame-level reference model ----------------
    logic       m_busy = 1'b0;
    logic       m_full = 1'b0;
    logic       m_done = 1'b0;
    logic       m_xfer;
    logic [7:0] m_buf = '0;
    logic [7:0] m_cur = '0;
    int         m_t = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        m_xfer = !m_busy && m_full;
        if (reset) begin
            m_busy = 1'b0;
            m_full = 1'b0;
            m_done = 1'b0;
            m_t    = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (s_tick) begin
                    m_t++;
                    if (m_t == FRAME_TICKS) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (m_xfer) begin
                m_busy = 1'b1;
                m_t    = 0;
                m_cur  = m_buf;
            end
            if (wr && (!m_full || m_xfer)) begin
                m_buf  = din;
                m_full = 1'b1;
            end else if (m_xfer) begin
                m_full = 1'b0;
            end
        end
        #1;
        if (!reset) begin
            chk("model_tx", 32'(tx), 32'(m_busy ? exp_bit(m_cur, m_t / 16) : 1'b1));
            chk("model_full", 32'(full), 32'(m_full));
            chk("model_busy", 32'(tx_busy), 32'(m_busy));
            chk("model_done", 32'(tx_done_tick), 32'(m_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic w, input logic [7:0] d, input logic t);
        @(negedge clock);
        wr = w;
        din = d;
        s_tick = t;
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_tx_low(output int c0);
        c0 = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #2;
            if (tx == 1'b0) begin
                c0 = cyc;
                return;
            end
        end
        chk("timeout_tx_low", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #2;
            if (tx_done_tick == 1'b1) begin
                c = cyc;
                return;
            end
        end
        chk("timeout_done", 32'd0, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0, cd, seen, ndone, t2, frz;
        logic [7:0] word;
        logic prev;
        logic exp_a5 [0:NB-1];
`ifdef UART_TX_PARITY_EN
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done_tick), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        repeat (5) drive(1'b0, 8'h00, 1'b1);
        chk("idle_tx", 32'(tx), 32'd1);

        // 0xA5 with s_tick every cycle
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        wait_tx_low(c0);
        for (int k = 0; k < NB; k++) begin
            goto(c0 + 16 * k + 8);
            chk($sformatf("a5_bit%0d", k), 32'(tx), 32'(exp_a5[k]));
        end
        wait_done(cd);
        chk("a5_done_cycles", 32'(cd - c0), 32'(FRAME_TICKS));

        // Back-to-back frames: 0x3C then 0xC3 written mid-frame
        drive(1'b1, 8'h3C, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        wait_tx_low(c0);
        goto(c0 + 40);
        chk("b2b_full_before", 32'(full), 32'd0);
        drive(1'b1, 8'hC3, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("b2b_full_after", 32'(full), 32'd1);
        wait_done(cd);
        @(posedge clock);
        #2;
        chk("b2b_no_gap", 32'({tx_busy, tx}), 32'(2'b10));

        // Write while full is dropped: 0x5A accepted, 0x11 discarded
        goto(cyc + 20);
        drive(1'b1, 8'h5A, 1'b1);
        drive(1'b1, 8'h11, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        wait_done(cd);
        wait_tx_low(c0);
        word = '0;
        for (int k = 1; k <= DBIT; k++) begin
            goto(c0 + 16 * k + 8);
            word[k-1] = tx;
        end
        chk("drop_data", 32'(word), 32'h5A);
        wait_done(cd);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #2;
            if (tx_busy || !tx) seen++;
        end
        chk("drop_no_third_frame", 32'(seen), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++)
            drive(($urandom_range(0, 29) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
        ndone = 0;
        for (int i = 0; i < 600; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (tx_done_tick) ndone++;
        end
        chk("rand_drained_busy", 32'(tx_busy), 32'd0);

        // Reset during data bit 3 with a word pending
        drive(1'b1, 8'h96, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        wait_tx_low(c0);
        drive(1'b1, 8'h44, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        goto(c0 + 16 * 4 + 5);
        chk("mid_full_pending", 32'(full), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (tx_busy || !tx) seen++;
        end
        chk("mid_rst_no_frame", 32'(seen), 32'd0);

        // SB_TICK=32 instance: 0xFF, s_tick gated low 5 cycles mid-frame
        @(negedge clock);
        s_tick2 = 1'b1;
        wr2 = 1'b1;
        din2 = 8'hFF;
        @(negedge clock);
        wr2 = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !tx_busy2; i++) @(negedge clock);
        chk("sb32_started", 32'(tx_busy2), 32'd1);
        t2 = 0;
        frz = 0;
        cd = -1;
        prev = tx2;
        for (int i = 0; i < 500; i++) begin
            s_tick2 = !(t2 == 40 && frz < 5);
            if (!s_tick2) frz++;
            @(posedge clock);
            if (s_tick2) t2++;
            #2;
            if (!s_tick2) chk("sb32_frozen", 32'(tx2), 32'(prev));
            if (t2 < 16) chk("sb32_start_low", 32'(tx2), 32'd0);
            if (t2 >= D2_DONE - 32 && !tx_done_tick2) chk("sb32_stop_high", 32'(tx2), 32'd1);
            prev = tx2;
            if (tx_done_tick2) begin
                cd = t2;
                break;
            end
            @(negedge clock);
        end
        chk("sb32_done_tick", 32'(cd), 32'(D2_DONE));
        chk("sb32_freeze_len", 32'(frz), 32'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame.
REQ-002 Parameter SB_TICK, default 16: s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clock  input  1  system clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 s_tick  input  1  baud-rate tick, 16 per bit period, one clock wide.
REQ-006 wr  input  1  host write strobe.
REQ-007 din  input  DBIT  host write data.
REQ-008 full  output  1  holding buffer occupied; host shall not write.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 tx_busy  output  1  a frame is in progress (state not idle).
REQ-011 tx_done_tick  output  1  one-clock pulse at frame end.

Function
REQ-012 Single-entry holding buffer: wr with full=0 loads din and sets full on the next edge.
REQ-013 wr with full=1 is ignored; buffer contents are unchanged and the data is dropped.
REQ-014 FSM states: IDLE, START, DATA, STOP, plus PARITY when enabled; encoding per shared package.
REQ-015 IDLE with full=1: next edge enters START, copies the buffer to the shift register, clears full, and zeroes tick counter s.
REQ-016 A wr in the same cycle as the REQ-015 transfer is accepted: load wins over clear, so full stays 1 with the new data.
REQ-017 Tick counter s (4 bits) advances only on s_tick; s_tick is ignored in IDLE.
REQ-018 START drives tx=0 for 16 ticks; at s==15 with s_tick, enter DATA with s=0 and bit counter n=0.
REQ-019 DATA drives tx=shift[0] (LSB first); every 16 ticks shift right and increment n; after n==DBIT-1, leave DATA.
REQ-020 STOP drives tx=1 for SB_TICK ticks; at s==SB_TICK-1 with s_tick, pulse tx_done_tick and return to IDLE.
REQ-021 tx is a registered output with no combinational glitches; tx=1 in IDLE.
REQ-022 A buffered word starts at the first edge after the IDLE return, so frames run back to back with no extra idle bit.
REQ-023 Frame length equals (1+DBIT+SB_TICK/16) bit periods, plus one when parity is enabled.

Reset
REQ-024 Reset gives: state IDLE, tx=1, full=0, tx_busy=0, tx_done_tick=0, counters and shift register 0.
REQ-025 Reset mid-frame aborts the frame immediately; tx returns high and the buffered data is discarded.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY state follows DATA and drives the even-parity bit (XOR of the DBIT data bits) for 16 ticks, then enters STOP.
REQ-027 UART_TX_PARITY_EN undefined: no PARITY state or logic; DATA goes directly to STOP.

Structure
REQ-028 Shared package uart_pkg holds the state typedef, the ticks-per-bit constant 16, and default DBIT/SB_TICK values.
REQ-029 The holding buffer is the sub-module tx_hold_buf, with ports clock, reset, set, clear, d, q, full.
REQ-030 The FSM, counters and shift register live in uart_tx.

Verification
REQ-031 s_tick every cycle, write 0xA5 -> tx reads 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks; tx_done_tick after 160 ticks.
REQ-032 Write 0x3C, then write 0xC3 during the frame -> two back-to-back frames, no idle gap; full is 0 only between the transfer and the second write.
REQ-033 Write 0x11 with full=1 during the transfer-pending cycle -> second write dropped, only one frame emitted.
REQ-034 Reset asserted during DATA bit 3 -> tx=1 and full=0 at once; after release, no frame until a new wr.
REQ-035 UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 after the data bits, frame 176 ticks; write 0x03 -> parity bit 0.
REQ-036 SB_TICK=32, write 0xFF -> stop high for 32 ticks, tx_done_tick at tick 176, s_tick held low for 5 cycles freezes tx with no change.
